// File: rtl/alu_cmd_issuer.sv
// Command issuer for the signed ALU: accepts one op at a time, drives A/B/ALU_FUN,
// waits for the selected unit flag (or times out) and returns the result. Stats: ALU_ISSUER_STATS_EN.
module alu_cmd_issuer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [3:0]         cmd_fun,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_fun,
    input  logic [2*WIDTH:0]   arith_out,
    input  logic [WIDTH-1:0]   logic_out,
    input  logic [WIDTH-1:0]   cmp_out,
    input  logic [WIDTH-1:0]   shift_out,
    input  logic               arith_flag,
    input  logic               logic_flag,
    input  logic               cmp_flag,
    input  logic               shift_flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH:0]   rsp_data,
    output logic [3:0]         rsp_fun,
`ifdef ALU_ISSUER_STATS_EN
    output logic [15:0]        op_count,
    output logic [15:0]        err_count,
`endif
    output logic               rsp_err
);

    localparam int unsigned RW         = 2 * WIDTH + 1;
    localparam logic [3:0]  TimeoutVal = 4'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [3:0]        fun_q, fun_d;
    logic [RW-1:0]     data_q, data_d;
    logic [3:0]        rfun_q, rfun_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        cnt_inc;

    logic              sel_flag;
    logic [RW-1:0]     sel_data;
    logic              accept;
    logic              hit;
    logic              expire;
    logic              rsp_hs;

    // Only the unit addressed by the latched function can complete the op.
    always_comb begin
        sel_flag = 1'b0;
        sel_data = '0;
        unique case (fun_q[3:2])
            2'b00: begin
                sel_flag = arith_flag;
                sel_data = arith_out;
            end
            2'b01: begin
                sel_flag = logic_flag;
                sel_data = {{(WIDTH + 1){1'b0}}, logic_out};
            end
            2'b10: begin
                sel_flag = cmp_flag;
                sel_data = {{(WIDTH + 1){1'b0}}, cmp_out};
            end
            2'b11: begin
                sel_flag = shift_flag;
                sel_data = {{(WIDTH + 1){1'b0}}, shift_out};
            end
            default: ;
        endcase
    end

    assign cnt_inc = cnt_q + 4'd1;
    assign accept  = cmd_valid && (state_q == StIdle);
    assign hit     = (state_q == StWait) && sel_flag;
    assign expire  = (state_q == StWait) && !sel_flag && (cnt_inc == TimeoutVal);
    assign rsp_hs  = (state_q == StResp) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)         state_d = StIssue;
            StIssue:                     state_d = StWait;
            StWait:  if (hit || expire)  state_d = StResp;
            StResp:  if (rsp_hs)         state_d = StIdle;
            default:                     state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        fun_d  = fun_q;
        data_d = data_q;
        rfun_d = rfun_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (accept) begin
            a_d   = cmd_a;
            b_d   = cmd_b;
            fun_d = cmd_fun;
        end
        if (state_q == StIssue) begin
            cnt_d = '0;
        end else if ((state_q == StWait) && !sel_flag) begin
            cnt_d = cnt_inc;
        end
        if (hit) begin
            data_d = sel_data;
            rfun_d = fun_q;
            err_d  = 1'b0;
        end else if (expire) begin
            data_d = '0;
            rfun_d = fun_q;
            err_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            fun_q  <= '0;
            data_q <= '0;
            rfun_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            fun_q  <= fun_d;
            data_q <= data_d;
            rfun_q <= rfun_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_fun  = fun_q;
    assign rsp_data = data_q;
    assign rsp_fun  = rfun_q;
    assign rsp_err  = err_q;

`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] op_cnt_q, op_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;
        if (rsp_hs) begin
            if (op_cnt_q != 16'hFFFF) op_cnt_d = op_cnt_q + 16'd1;
            if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign op_count  = op_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized bench for alu_cmd_issuer: the ALU side is played by the bench, which decides
// per op when (or whether) the addressed flag rises and predicts the response from that.
module tb_alu_cmd_issuer;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 4;
    localparam int unsigned RW = 2 * W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a, cmd_b;
    logic [3:0]    cmd_fun;
    logic [W-1:0]  alu_a, alu_b;
    logic [3:0]    alu_fun;
    logic [RW-1:0] arith_out;
    logic [W-1:0]  logic_out, cmp_out, shift_out;
    logic          arith_flag, logic_flag, cmp_flag, shift_flag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_data;
    logic [3:0]    rsp_fun;
    logic          rsp_err;
`ifdef ALU_ISSUER_STATS_EN
    logic [15:0]   op_count, err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ops = 0;
    int exp_errs = 0;
    logic hold_arith = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_fun    (cmd_fun),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fun    (alu_fun),
        .arith_out  (arith_out),
        .logic_out  (logic_out),
        .cmp_out    (cmp_out),
        .shift_out  (shift_out),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_fun    (rsp_fun),
`ifdef ALU_ISSUER_STATS_EN
        .op_count   (op_count),
        .err_count  (err_count),
`endif
        .rsp_err    (rsp_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Random noise on every ALU output; the addressed unit then gets the given flag/value.
    task automatic drive_alu(input logic [1:0] unit, input logic flag, input logic [RW-1:0] val);
        arith_out  = RW'({$urandom(), $urandom()});
        logic_out  = W'($urandom());
        cmp_out    = W'($urandom());
        shift_out  = W'($urandom());
        arith_flag = hold_arith ? 1'b1 : 1'($urandom());
        logic_flag = 1'($urandom());
        cmp_flag   = 1'($urandom());
        shift_flag = 1'($urandom());
        case (unit)
            2'd0: begin arith_flag = flag || hold_arith; if (flag) arith_out = val; end
            2'd1: begin logic_flag = flag; if (flag) logic_out = val[W-1:0]; end
            2'd2: begin cmp_flag = flag; if (flag) cmp_out = val[W-1:0]; end
            default: begin shift_flag = flag; if (flag) shift_out = val[W-1:0]; end
        endcase
    endtask

    // k = WAIT cycle in which the addressed flag rises (outside 1..TO: never); bp = stall cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fun,
                          input int k, input int bp, input logic [RW-1:0] val,
                          input logic stale);
        logic          exp_err;
        logic [RW-1:0] exp_data;
        int            last;
        exp_err  = !(k >= 1 && k <= int'(TO));
        last     = exp_err ? int'(TO) : k;
        exp_data = exp_err ? '0 : val;

        check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = fun;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a     = W'($urandom());
        cmd_b     = W'($urandom());
        cmd_fun   = 4'($urandom());
        check_eq("alu_a", 64'(alu_a), 64'(a));
        check_eq("alu_b", 64'(alu_b), 64'(b));
        check_eq("alu_fun", 64'(alu_fun), 64'(fun));
        check_eq("cmd_ready_issue", 64'(cmd_ready), 64'd0);
        // A stale flag during ISSUE must not complete the op.
        drive_alu(fun[3:2], stale, RW'({$urandom(), $urandom()}) | 64'h1);
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            check_eq("rsp_early", 64'(rsp_valid), 64'd0);
            drive_alu(fun[3:2], j == k, val);
        end
        @(negedge clk);
        drive_alu(fun[3:2], 1'($urandom()), RW'({$urandom(), $urandom()}));
        check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("rsp_data", 64'(rsp_data), 64'(exp_data));
        check_eq("rsp_fun", 64'(rsp_fun), 64'(fun));
        check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
        check_eq("cmd_ready_resp", 64'(cmd_ready), 64'd0);
        for (int j = 0; j < bp; j++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            drive_alu(fun[3:2], 1'($urandom()), RW'({$urandom(), $urandom()}));
            check_eq("bp_valid", 64'(rsp_valid), 64'd1);
            check_eq("bp_data", 64'(rsp_data), 64'(exp_data));
            check_eq("bp_fun", 64'(rsp_fun), 64'(fun));
            check_eq("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_hs_valid", 64'(rsp_valid), 64'd0);
        check_eq("post_hs_ready", 64'(cmd_ready), 64'd1);
        check_eq("alu_fun_held", 64'(alu_fun), 64'(fun));
        exp_ops++;
        if (exp_err) exp_errs++;
    endtask

    task automatic run_reset_mid_wait();
        cmd_valid = 1'b1;
        cmd_a     = 16'h1234;
        cmd_b     = 16'h4321;
        cmd_fun   = 4'b1001;
        @(negedge clk);
        cmd_valid = 1'b0;
        drive_alu(2'd2, 1'b0, '0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            drive_alu(2'd2, 1'b0, '0);
        end
        rst = 1'b1;
        drive_alu(2'd2, 1'b1, 33'h5A5A);
        @(negedge clk);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_alu_fun", 64'(alu_fun), 64'd0);
        check_eq("rst_alu_a", 64'(alu_a), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_eq("rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        exp_ops  = 0;
        exp_errs = 0;
    endtask

    initial begin
        logic [3:0]    fun;
        logic [RW-1:0] val;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_fun   = '0;
        rsp_ready = 1'b0;
        drive_alu(2'd0, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("reset_alu_a", 64'(alu_a), 64'd0);
        check_eq("reset_alu_b", 64'(alu_b), 64'd0);
        check_eq("reset_alu_fun", 64'(alu_fun), 64'd0);
        check_eq("reset_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("reset_rsp_fun", 64'(rsp_fun), 64'd0);
        check_eq("reset_rsp_err", 64'(rsp_err), 64'd0);

        // Add 3+5, flag in first WAIT cycle.
        run_op(16'd3, 16'd5, 4'b0000, 1, 0, 33'd8, 1'b0);
        // Logic op with arith_flag stuck high.
        hold_arith = 1'b1;
        run_op(16'h00F0, 16'h0F0F, 4'b0100, 2, 0, 33'h0, 1'b0);
        hold_arith = 1'b0;
        // Compare op whose flag never arrives.
        run_op(16'h0007, 16'h0009, 4'b1000, 0, 0, 33'h0, 1'b0);
        // Shift op held under 5 cycles of backpressure.
        run_op(16'h8001, 16'h0003, 4'b1100, 1, 5, 33'h1000, 1'b1);
        // Flag in the last WAIT cycle before timeout.
        run_op(16'h0100, 16'h0010, 4'b1011, int'(TO), 1, 33'h00FF, 1'b1);
`ifdef ALU_ISSUER_STATS_EN
        check_eq("op_count_5", 64'(op_count), 64'd5);
        check_eq("err_count_5", 64'(err_count), 64'd1);
`endif

        run_reset_mid_wait();
`ifdef ALU_ISSUER_STATS_EN
        check_eq("op_count_rst", 64'(op_count), 64'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            fun = 4'($urandom());
            val = RW'({$urandom(), $urandom()});
            if (fun[3:2] != 2'b00) val = RW'(val[W-1:0]);
            run_op(W'($urandom()), W'($urandom()), fun, $urandom_range(0, TO + 1),
                   $urandom_range(0, 3), val, 1'($urandom()));
        end
`ifdef ALU_ISSUER_STATS_EN
        check_eq("op_count_end", 64'(op_count), 64'(exp_ops));
        check_eq("err_count_end", 64'(err_count), 64'(exp_errs));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
